earth_tx_arbiter: RTL
=====================

Name: earth_tx_arbiter

Overview:
- Shares the Ethernet TX FIFO between two packet requesters: req0 is the camera uplink-command generator and req1 is the status/telemetry reporter.
- On each rising edge of en, flushes the TX FIFO, then grants packets round-robin.
- Packets are atomic: the granted source streams all its 64-bit words into the FIFO before any other grant.
- Per packet, drives tx_data_length and tx_total_length for the Ethernet TX core.

Parameters:
- WORDS_MAX, 16: maximum words per packet; larger requests are clamped.
- HDR_BYTES, 42: header bytes added to the payload to form tx_total_length.
- FLUSH_MAX, 64: maximum cycles etx_fifo_rst is held in FLUSH.
- GAP_CYC, 4: idle cycles after each packet (only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  block enable; a rising edge starts flush and arbitration.
- req  in  2  per-source packet request; held high until pkt_done for that source.
- req0_len, req1_len  in  8  packet length in 64-bit words; sampled at grant.
- req0_din, req1_din  in  64  first-word-fall-through data from each source.
- rd  out  2  per-source word pop; combinational, one-hot or zero.
- gnt  out  2  registered one-hot grant; held for the whole packet.
- etx_din  out  64  TX FIFO write data; registered.
- ewr_en  out  1  TX FIFO write enable; registered.
- etx_full  in  1  TX FIFO full.
- etx_empty  in  1  TX FIFO empty.
- etx_fifo_rst  out  1  TX FIFO reset.
- tx_data_length  out  16  payload bytes for the current packet.
- tx_total_length  out  16  tx_data_length + HDR_BYTES.
- busy  out  1  high in FLUSH, SEND and GAP.
- pkt_done  out  2  one-cycle pulse per source when its last word is written.

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer selects req0 first; word counter 0.
- en_d is a registered copy of en; a rising edge of en is en & ~en_d.

State machine:
- IDLE:
  - On an en rising edge, go to FLUSH.
  - Otherwise, if en is high (already flushed), go to ARB.
- FLUSH:
  - etx_fifo_rst = 1 while etx_empty = 0 and the flush counter is below FLUSH_MAX.
  - When etx_empty = 1 or the counter reaches FLUSH_MAX, drive etx_fifo_rst = 0 and go to ARB the next cycle.
- ARB:
  - A source is eligible when its req = 1 and its len ≠ 0.
  - Zero-length requests are never granted; the source must drop req.
  - If both sources are eligible, grant the one not granted last; if one is eligible, grant it.
  - On grant:
    - latch len = min(len, WORDS_MAX);
    - set gnt;
    - tx_data_length = len × 8;
    - tx_total_length = len × 8 + HDR_BYTES (16-bit arithmetic; no overflow at the maximum of 16 words);
    - update the pointer;
    - go to SEND.
  - If no source is eligible, stay in ARB.
- SEND:
  - Each cycle with etx_full = 0:
    - rd[g] = 1;
    - etx_din <= req_g_din;
    - ewr_en <= 1;
    - count++.
  - When etx_full = 1: rd = 0, ewr_en <= 0, and the counter holds (the packet stalls and is never split).
  - On the write where count+1 == len:
    - pkt_done[g] pulses in the same cycle ewr_en is asserted for that last word;
    - gnt clears;
    - go to GAP (feature on) or ARB (feature off).
- Latency:
  - A request present in the ARB cycle causes the first ewr_en two cycles later.
  - With etx_full low, words are written back-to-back, one per cycle.
- en low in any state:
  - Abort immediately: ewr_en <= 0, rd = 0, gnt = 0, no pkt_done, go to IDLE.
  - A partial packet may remain in the FIFO; the next en rise flushes it.
- tx_data_length and tx_total_length hold their values until the next grant.
- rst has priority over en; rst mid-packet behaves like reset, with no pkt_done.

Optional Feature:
- Macro: EARTH_TX_GAP_EN.
- Defined: after pkt_done, the GAP state holds ewr_en = 0 and rd = 0 for GAP_CYC cycles, then goes to ARB. busy stays high during GAP.
- Undefined: the GAP state and its counter are not built; SEND goes straight to ARB, so a back-to-back packet starts its first write two cycles after the previous last write.

Test Plan:
- Reset, then raise en with etx_empty = 0 for 5 cycles -> etx_fifo_rst high for exactly those 5 cycles, then ARB; with etx_empty stuck at 0 -> etx_fifo_rst drops after 64 cycles.
- req0 with len 2, data 0xA, 0xB -> ewr_en high for 2 cycles, etx_din sequence A, B; tx_data_length 16, tx_total_length 58; pkt_done[0] pulses on the second write.
- req0 and req1 both held with len 3, sent 4 packets -> grants alternate 0,1,0,1; no interleaving of words inside a packet.
- etx_full raised for 3 cycles in the middle of a 4-word packet -> ewr_en and rd low for those cycles; all 4 words delivered in order.
- en dropped after the 2nd word of an 8-word packet -> ewr_en 0 next cycle, no pkt_done; on en re-rise, FLUSH asserts etx_fifo_rst.
- req1 with len 0 and req0 with len 20 -> req1 never granted; req0 clamped to 16 words, tx_data_length 128; with EARTH_TX_GAP_EN, 4 idle cycles occur before the next grant.

Source files
------------

// File: rtl/earth_tx_arbiter.sv
// Round-robin arbiter sharing the Ethernet TX FIFO between two packet sources.
// Optional inter-packet idle gap is built when EARTH_TX_GAP_EN is defined.
`timescale 1ns/1ps

module earth_tx_arbiter #(
    parameter int WORDS_MAX = 16,
    parameter int HDR_BYTES = 42,
    parameter int FLUSH_MAX = 64,
    parameter int GAP_CYC   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  req,
    input  logic [7:0]  req0_len,
    input  logic [7:0]  req1_len,
    input  logic [63:0] req0_din,
    input  logic [63:0] req1_din,
    output logic [1:0]  rd,
    output logic [1:0]  gnt,
    output logic [63:0] etx_din,
    output logic        ewr_en,
    input  logic        etx_full,
    input  logic        etx_empty,
    output logic        etx_fifo_rst,
    output logic [15:0] tx_data_length,
    output logic [15:0] tx_total_length,
    output logic        busy,
    output logic [1:0]  pkt_done,
    output logic [2:0]  dbg_state
);

`ifdef EARTH_TX_GAP_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_FLUSH = 3'd1, S_ARB = 3'd2, S_SEND = 3'd3, S_GAP = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_FLUSH = 3'd1, S_ARB = 3'd2, S_SEND = 3'd3
    } state_t;
`endif

    localparam int          FW        = $clog2(FLUSH_MAX + 1);
    localparam logic [FW-1:0] FLUSH_LIM = FW'(FLUSH_MAX);
    localparam logic [7:0]  WMAX      = 8'(WORDS_MAX);
    localparam logic [15:0] HDR16     = 16'(HDR_BYTES);

    state_t        state, state_n;
    logic          en_d;
    logic          en_rise;
    logic [FW-1:0] flush_cnt;
    logic [7:0]    len_q;
    logic [7:0]    word_cnt;
    logic          prio;       // source that wins a tie (the one not granted last)
    logic          g_idx;
    logic          elig0, elig1;
    logic          grant_sel;
    logic [7:0]    sel_len;
    logic [7:0]    clamped_len;
    logic          do_grant;
    logic          do_write;
    logic          last_word;

    assign en_rise   = en & ~en_d;
    assign elig0     = req[0] && (req0_len != 8'd0);
    assign elig1     = req[1] && (req1_len != 8'd0);
    assign grant_sel = (elig0 && elig1) ? prio : elig1;
    assign sel_len   = grant_sel ? req1_len : req0_len;
    assign clamped_len = (sel_len > WMAX) ? WMAX : sel_len;
    assign last_word = (word_cnt + 8'd1) == len_q;
    assign dbg_state = state;

`ifdef EARTH_TX_GAP_EN
    localparam int          GW       = $clog2(GAP_CYC + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
    logic [GW-1:0] gap_cnt;

    always_ff @(posedge clk) begin
        if (rst || state != S_GAP) gap_cnt <= '0;
        else                       gap_cnt <= gap_cnt + 1'b1;
    end

    assign busy = (state == S_FLUSH) || (state == S_SEND) || (state == S_GAP);
`else
    assign busy = (state == S_FLUSH) || (state == S_SEND);
`endif

    // Source handshake: rd pops the granted FWFT source in the same cycle its
    // din is captured; a write happens only when etx_full is low, so a full
    // FIFO stalls the packet in place without dropping or splitting words.
    always_comb begin
        state_n      = state;
        etx_fifo_rst = 1'b0;
        rd           = 2'b00;
        do_grant     = 1'b0;
        do_write     = 1'b0;
        case (state)
            S_IDLE: begin
                if (en_rise)  state_n = S_FLUSH;
                else if (en)  state_n = S_ARB;
            end
            S_FLUSH: begin
                if (!etx_empty && flush_cnt < FLUSH_LIM) etx_fifo_rst = 1'b1;
                else                                      state_n = S_ARB;
            end
            S_ARB: begin
                if (elig0 || elig1) begin
                    do_grant = 1'b1;
                    state_n  = S_SEND;
                end
            end
            S_SEND: begin
                if (!etx_full) begin
                    rd[g_idx] = 1'b1;
                    do_write  = 1'b1;
`ifdef EARTH_TX_GAP_EN
                    if (last_word) state_n = S_GAP;
`else
                    if (last_word) state_n = S_ARB;
`endif
                end
            end
`ifdef EARTH_TX_GAP_EN
            S_GAP: begin
                if (gap_cnt == GAP_LAST) state_n = S_ARB;
            end
`endif
            default: state_n = S_IDLE;
        endcase
        // Dropping en aborts from any state, including mid-packet.
        if (!en) begin
            state_n      = S_IDLE;
            etx_fifo_rst = 1'b0;
            rd           = 2'b00;
            do_grant     = 1'b0;
            do_write     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            en_d            <= 1'b0;
            flush_cnt       <= '0;
            len_q           <= 8'd0;
            word_cnt        <= 8'd0;
            prio            <= 1'b0;
            g_idx           <= 1'b0;
            gnt             <= 2'b00;
            etx_din         <= 64'd0;
            ewr_en          <= 1'b0;
            tx_data_length  <= 16'd0;
            tx_total_length <= 16'd0;
            pkt_done        <= 2'b00;
        end else begin
            state    <= state_n;
            en_d     <= en;
            ewr_en   <= do_write;
            pkt_done <= 2'b00;

            if (state != S_FLUSH)  flush_cnt <= '0;
            else if (etx_fifo_rst) flush_cnt <= flush_cnt + 1'b1;

            if (do_grant) begin
                gnt             <= grant_sel ? 2'b10 : 2'b01;
                g_idx           <= grant_sel;
                prio            <= ~grant_sel;
                len_q           <= clamped_len;
                word_cnt        <= 8'd0;
                tx_data_length  <= {5'd0, clamped_len, 3'd0};
                tx_total_length <= {5'd0, clamped_len, 3'd0} + HDR16;
            end

            if (do_write) begin
                etx_din  <= g_idx ? req1_din : req0_din;
                word_cnt <= word_cnt + 8'd1;
                if (last_word) begin
                    pkt_done[g_idx] <= 1'b1;
                    gnt             <= 2'b00;
                    word_cnt        <= 8'd0;
                end
            end

            if (!en) begin
                gnt      <= 2'b00;
                word_cnt <= 8'd0;
            end
        end
    end

endmodule
